// File: rtl/gesture_classify_scheduler_if.sv
// rtl/gesture_classify_scheduler_if.sv - activity-map/classifier handshake bundle for the classify scheduler
interface gesture_classify_scheduler_if #(
    parameter int CNT_WIDTH_P = 16
);
    logic                   enable_i;
    logic                   event_accept_i;
    logic                   decay_triggered_i;
    logic                   classify_busy_i;
    logic                   classify_trigger_o;
    logic [1:0]             sched_state_o;
    logic [CNT_WIDTH_P-1:0] events_in_window_o;
    logic [7:0]             overrun_count_o;
    logic                   ack_error_o;

    modport master (
        output enable_i,
        output event_accept_i,
        output decay_triggered_i,
        output classify_busy_i,
        input  classify_trigger_o,
        input  sched_state_o,
        input  events_in_window_o,
        input  overrun_count_o,
        input  ack_error_o
    );

    modport slave (
        input  enable_i,
        input  event_accept_i,
        input  decay_triggered_i,
        input  classify_busy_i,
        output classify_trigger_o,
        output sched_state_o,
        output events_in_window_o,
        output overrun_count_o,
        output ack_error_o
    );
endinterface

// File: rtl/gesture_classify_scheduler.sv
// rtl/gesture_classify_scheduler.sv - classification pass scheduler; GESTURE_SCHED_TIMEOUT_EN adds the idle-timeout path
module gesture_classify_scheduler #(
    parameter int EVENT_THRESH_P   = 64,
    parameter int MIN_EVENTS_P     = 8,
    parameter int TIMEOUT_CYCLES_P = 100000,
    parameter int ACK_TIMEOUT_P    = 8,
    parameter int CNT_WIDTH_P      = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    gesture_classify_scheduler_if.slave sched_if
);
    typedef enum logic [1:0] {
        COLLECT   = 2'd0,
        FIRE      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam int ACK_W = $clog2(ACK_TIMEOUT_P + 1);
    localparam logic [CNT_WIDTH_P-1:0] CNT_MAX  = {CNT_WIDTH_P{1'b1}};
    localparam logic [CNT_WIDTH_P-1:0] CNT_ONE  = CNT_WIDTH_P'(1);
    localparam logic [CNT_WIDTH_P-1:0] THRESH_C = CNT_WIDTH_P'(EVENT_THRESH_P);
    localparam logic [CNT_WIDTH_P-1:0] MIN_C    = CNT_WIDTH_P'(MIN_EVENTS_P);
    localparam logic [ACK_W-1:0]       ACK_LAST = ACK_W'(ACK_TIMEOUT_P - 1);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH_P-1:0] cnt_q, cnt_d, cnt_inc;
    logic [ACK_W-1:0]       ack_cnt_q, ack_cnt_d;
    logic [7:0]             ovr_q, ovr_d;
    logic                   ovr_seen_q, ovr_seen_d;
    logic                   ack_err_q, ack_err_d;
    logic                   trig_q;
    logic                   fc;
    logic                   timeout_hit;
    logic                   low_count_timeout;
    logic                   ack_expired;
    logic                   waiting;

    assign cnt_inc = (sched_if.event_accept_i && (cnt_q != CNT_MAX)) ? cnt_q + CNT_ONE : cnt_q;

`ifdef GESTURE_SCHED_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES_P + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES_P - 1);

    logic [TMR_W-1:0] timer_q, timer_d;

    assign timeout_hit = (state_q == COLLECT) && (timer_q == TMR_LAST);

    // Timer restarts at zero every time COLLECT is (re-)entered and whenever the window is discarded.
    always_comb begin
        timer_d = '0;
        if ((state_q == COLLECT) && (state_d == COLLECT) && sched_if.enable_i && !timeout_hit) begin
            timer_d = timer_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Decision uses the registered count, so a coincident accept lands in the next window.
    assign fc = (cnt_q >= THRESH_C)
             || (sched_if.decay_triggered_i && (cnt_q >= MIN_C))
             || (timeout_hit && (cnt_q >= MIN_C));

    assign low_count_timeout = timeout_hit && (cnt_q < MIN_C);
    assign ack_expired       = (ack_cnt_q == ACK_LAST);
    assign waiting           = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: begin
                if (sched_if.enable_i && fc) begin
                    state_d = FIRE;
                end
            end
            FIRE: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (sched_if.classify_busy_i) begin
                    state_d = WAIT_DONE;
                end else if (ack_expired) begin
                    state_d = COLLECT;
                end
            end
            WAIT_DONE: begin
                if (!sched_if.classify_busy_i) begin
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_comb begin
        cnt_d      = cnt_inc;
        ack_cnt_d  = '0;
        ovr_d      = ovr_q;
        ovr_seen_d = ovr_seen_q;
        ack_err_d  = ack_err_q;
        case (state_q)
            COLLECT: begin
                if (!sched_if.enable_i) begin
                    cnt_d = '0;
                end else if (fc || low_count_timeout) begin
                    cnt_d = sched_if.event_accept_i ? CNT_ONE : '0;
                end
            end
            FIRE: begin
                ovr_seen_d = 1'b0;
            end
            WAIT_BUSY: begin
                ack_cnt_d = ack_cnt_q + ACK_W'(1);
                if (!sched_if.classify_busy_i && ack_expired) begin
                    ack_err_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
        // At most one overrun is recorded per pass, however long fc stays asserted.
        if (waiting && fc && !ovr_seen_q) begin
            ovr_seen_d = 1'b1;
            if (ovr_q != 8'hFF) begin
                ovr_d = ovr_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            cnt_q      <= '0;
            ack_cnt_q  <= '0;
            ovr_q      <= '0;
            ovr_seen_q <= 1'b0;
            ack_err_q  <= 1'b0;
            trig_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            ack_cnt_q  <= ack_cnt_d;
            ovr_q      <= ovr_d;
            ovr_seen_q <= ovr_seen_d;
            ack_err_q  <= ack_err_d;
            trig_q     <= (state_d == FIRE);
        end
    end

    assign sched_if.classify_trigger_o = trig_q;
    assign sched_if.sched_state_o      = state_q;
    assign sched_if.events_in_window_o = cnt_q;
    assign sched_if.overrun_count_o    = ovr_q;
    assign sched_if.ack_error_o        = ack_err_q;
endmodule

// File: tb/tb_gesture_classify_scheduler.sv
// tb/tb_gesture_classify_scheduler.sv - self-checking bench for gesture_classify_scheduler
module tb_gesture_classify_scheduler;
    localparam int THRESH = 64;
    localparam int MIN_EV = 8;
    localparam int TMO    = 120;
    localparam int ACK    = 8;
    localparam int CW     = 16;
`ifdef GESTURE_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b1;
    logic accept = 1'b0;
    logic decay = 1'b0;
    logic busy = 1'b0;

    always #5 clk = ~clk;

    gesture_classify_scheduler_if #(.CNT_WIDTH_P(CW)) sif ();

    assign sif.enable_i          = enable;
    assign sif.event_accept_i    = accept;
    assign sif.decay_triggered_i = decay;
    assign sif.classify_busy_i   = busy;

    gesture_classify_scheduler #(
        .EVENT_THRESH_P  (THRESH),
        .MIN_EVENTS_P    (MIN_EV),
        .TIMEOUT_CYCLES_P(TMO),
        .ACK_TIMEOUT_P   (ACK),
        .CNT_WIDTH_P     (CW)
    ) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n),
        .sched_if (sif)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: one step per clock, straight from the scheduling rules.
    int m_state = 0, m_cnt = 0, m_timer = 0, m_wait = 0, m_ovr = 0;
    bit m_ack_err = 0, m_trig = 0, m_seen = 0, model_on = 0;

    always @(posedge clk) begin
        bit fc;
        int nc;
        int cmax;
        cmax = (1 << CW) - 1;
        if (!reset_n) begin
            m_state = 0; m_cnt = 0; m_timer = 0; m_wait = 0; m_ovr = 0;
            m_ack_err = 0; m_trig = 0; m_seen = 0; model_on = 1;
        end else if (model_on) begin
            fc = (m_cnt >= THRESH) || (decay && m_cnt >= MIN_EV)
              || (TO_EN && m_state == 0 && m_timer == TMO - 1 && m_cnt >= MIN_EV);
            nc = m_cnt + int'(accept);
            if (nc > cmax) nc = cmax;
            m_trig = 0;
            if ((m_state == 2 || m_state == 3) && fc && !m_seen) begin
                m_seen = 1;
                if (m_ovr < 255) m_ovr++;
            end
            case (m_state)
                0: begin
                    if (!enable) begin
                        m_cnt = 0; m_timer = 0;
                    end else if (fc) begin
                        m_state = 1; m_trig = 1; m_cnt = int'(accept); m_timer = 0; m_seen = 0;
                    end else if (TO_EN && m_timer == TMO - 1) begin
                        m_cnt = int'(accept); m_timer = 0;
                    end else begin
                        m_cnt = nc; m_timer = m_timer + 1;
                    end
                end
                1: begin
                    m_cnt = nc; m_state = 2; m_wait = 0;
                end
                2: begin
                    m_cnt = nc;
                    if (busy) m_state = 3;
                    else if (m_wait == ACK - 1) begin
                        m_state = 0; m_ack_err = 1;
                    end else m_wait++;
                end
                default: begin
                    m_cnt = nc;
                    if (!busy) m_state = 0;
                end
            endcase
        end
    end

    int trig_seen = 0;

    always @(negedge clk) begin
        if (model_on) begin
            chk("cyc_trigger", sif.classify_trigger_o, m_trig);
            chk("cyc_state", sif.sched_state_o, m_state);
            chk("cyc_events", sif.events_in_window_o, m_cnt);
            chk("cyc_overrun", sif.overrun_count_o, m_ovr);
            chk("cyc_ack_error", sif.ack_error_o, m_ack_err);
        end
        if (sif.classify_trigger_o === 1'b1) trig_seen++;
    end

    // Classifier stand-in: raises busy one cycle after seeing a trigger, for cls_hold cycles (0 = never).
    int cls_hold = 20;
    bit cls_rand = 0;
    int busy_left = 0;
    bit pending = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (pending) begin
                busy_left = cls_rand ? int'($urandom_range(0, 25)) : cls_hold;
                pending = 0;
            end
            busy = (busy_left > 0);
            if (busy_left > 0) busy_left--;
            if (sif.classify_trigger_o === 1'b1) pending = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit a, input bit d);
        accept = a;
        decay = d;
        tick();
    endtask

    task automatic do_reset();
        accept = 0;
        decay = 0;
        enable = 1;
        reset_n = 0;
        tick();
        for (int i = 0; i < 400 && (busy || pending); i++) tick();
        reset_n = 1;
    endtask

    task automatic wait_collect(input string name, input int limit);
        for (int i = 0; i < limit && sif.sched_state_o != 2'd0; i++) tick();
        chk(name, sif.sched_state_o, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;

        do_reset();
        chk("rst_trigger", sif.classify_trigger_o, 0);
        chk("rst_state", sif.sched_state_o, 0);
        chk("rst_events", sif.events_in_window_o, 0);
        chk("rst_overrun", sif.overrun_count_o, 0);
        chk("rst_ack_error", sif.ack_error_o, 0);

        // Threshold pass with a well-behaved classifier.
        n0 = trig_seen;
        cls_hold = 20;
        for (int i = 0; i < 64; i++) drive(1, 0);
        accept = 0;
        chk("thr_count64", sif.events_in_window_o, 64);
        chk("thr_no_early_trig", sif.classify_trigger_o, 0);
        tick();
        chk("thr_trigger", sif.classify_trigger_o, 1);
        chk("thr_state_fire", sif.sched_state_o, 1);
        chk("thr_count_cleared", sif.events_in_window_o, 0);
        tick();
        chk("thr_state_wait_busy", sif.sched_state_o, 2);
        chk("thr_trig_single", sif.classify_trigger_o, 0);
        tick();
        chk("thr_state_wait_done", sif.sched_state_o, 3);
        wait_collect("thr_back_collect", 100);
        chk("thr_one_trigger", trig_seen - n0, 1);

        // Decay path above and below the minimum.
        do_reset();
        for (int i = 0; i < 10; i++) drive(1, 0);
        drive(0, 1);
        decay = 0;
        chk("decay10_trigger", sif.classify_trigger_o, 1);
        wait_collect("decay10_back", 100);
        do_reset();
        for (int i = 0; i < 5; i++) drive(1, 0);
        drive(0, 1);
        decay = 0;
        chk("decay5_no_trigger", sif.classify_trigger_o, 0);
        chk("decay5_count", sif.events_in_window_o, 5);
        repeat (4) tick();
        chk("decay5_count_held", sif.events_in_window_o, 5);

`ifdef GESTURE_SCHED_TIMEOUT_EN
        do_reset();
        for (int i = 0; i < 9; i++) drive(1, 0);
        accept = 0;
        for (int i = 9; i < TMO - 1; i++) tick();
        chk("tmo9_before", sif.classify_trigger_o, 0);
        chk("tmo9_count", sif.events_in_window_o, 9);
        tick();
        chk("tmo9_trigger", sif.classify_trigger_o, 1);
        wait_collect("tmo9_back", 100);
        do_reset();
        for (int i = 0; i < 3; i++) drive(1, 0);
        accept = 0;
        for (int i = 3; i < TMO - 1; i++) tick();
        chk("tmo3_count_before", sif.events_in_window_o, 3);
        tick();
        chk("tmo3_count_cleared", sif.events_in_window_o, 0);
        chk("tmo3_no_trigger", sif.classify_trigger_o, 0);
`else
        do_reset();
        for (int i = 0; i < 3; i++) drive(1, 0);
        accept = 0;
        for (int i = 0; i < TMO + 10; i++) tick();
        chk("notmo3_count_persists", sif.events_in_window_o, 3);
`endif

        // Classifier that never acknowledges.
        do_reset();
        cls_hold = 0;
        for (int i = 0; i < 64; i++) drive(1, 0);
        accept = 0;
        tick();
        chk("ack_trigger", sif.classify_trigger_o, 1);
        repeat (8) tick();
        chk("ack_still_waiting", sif.sched_state_o, 2);
        chk("ack_err_not_yet", sif.ack_error_o, 0);
        tick();
        chk("ack_state_collect", sif.sched_state_o, 0);
        chk("ack_err_set", sif.ack_error_o, 1);
        cls_hold = 20;
        for (int i = 0; i < 64; i++) drive(1, 0);
        accept = 0;
        tick();
        chk("ack_refire", sif.classify_trigger_o, 1);
        chk("ack_err_sticky", sif.ack_error_o, 1);
        wait_collect("ack_back", 100);

        // Long busy period with events streaming in.
        do_reset();
        cls_hold = 300;
        for (int i = 0; i < 200; i++) drive(1, 0);
        accept = 0;
        wait_collect("ovr_back", 600);
        cls_hold = 5;
        chk("ovr_count", sif.overrun_count_o, 1);
        chk("ovr_pending_events", sif.events_in_window_o, 136);
        tick();
        chk("ovr_second_trigger", sif.classify_trigger_o, 1);
        wait_collect("ovr_second_back", 100);

        // Reset mid-pass, then disabled collection.
        do_reset();
        cls_hold = 50;
        for (int i = 0; i < 64; i++) drive(1, 0);
        accept = 0;
        for (int i = 0; i < 20 && sif.sched_state_o != 2'd3; i++) tick();
        chk("rstmid_in_wait_done", sif.sched_state_o, 3);
        reset_n = 0;
        tick();
        chk("rstmid_trigger", sif.classify_trigger_o, 0);
        chk("rstmid_state", sif.sched_state_o, 0);
        chk("rstmid_events", sif.events_in_window_o, 0);
        chk("rstmid_overrun", sif.overrun_count_o, 0);
        chk("rstmid_ack_error", sif.ack_error_o, 0);
        reset_n = 1;
        enable = 0;
        n0 = trig_seen;
        for (int i = 0; i < 100; i++) drive(1, 0);
        accept = 0;
        chk("dis_count_zero", sif.events_in_window_o, 0);
        chk("dis_no_trigger", trig_seen - n0, 0);
        enable = 1;

        // Randomised traffic against the reference model.
        cls_hold = 20;
        do_reset();
        cls_rand = 1;
        for (int seg = 0; seg < 8; seg++) begin
            int rate;
            rate = int'($urandom_range(1, 10));
            for (int i = 0; i < 500; i++) begin
                accept = ($urandom_range(0, 9) < rate);
                decay = ($urandom_range(0, 49) == 0);
                if ($urandom_range(0, 299) == 0) enable = ~enable;
                reset_n = ($urandom_range(0, 999) != 0);
                tick();
            end
        end
        reset_n = 1;
        accept = 0;
        decay = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
